// File: rtl/spi_rx_word.sv
// SPI slave receiver: synchronises SCK/MOSI/CS_n, frames MSB-first words on chip-select and
// presents them on a valid/ready port. Define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO.
module spi_rx_word #(
  parameter int SPI_MODE   = 0,
  parameter int WORD_BITS  = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_SPI_Clk,
  input  logic                 i_SPI_MOSI,
  input  logic                 i_SPI_CS_n,
  output logic [WORD_BITS-1:0] o_RX_Word,
  output logic                 o_RX_DV,
  input  logic                 i_RX_Ready,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun
);
  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int   CW   = $clog2(WORD_BITS + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_WAIT_CS = 2'd2;

  logic sck_s1_q, sck_s2_q, sck_h_q;
  logic mosi_s1_q, mosi_s2_q;
  logic cs_s1_q, cs_s2_q, cs_h_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_s1_q  <= CPOL;
      sck_s2_q  <= CPOL;
      sck_h_q   <= CPOL;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_h_q    <= 1'b1;
    end else begin
      sck_s1_q  <= i_SPI_Clk;
      sck_s2_q  <= sck_s1_q;
      sck_h_q   <= sck_s2_q;
      mosi_s1_q <= i_SPI_MOSI;
      mosi_s2_q <= mosi_s1_q;
      cs_s1_q   <= i_SPI_CS_n;
      cs_s2_q   <= cs_s1_q;
      cs_h_q    <= cs_s2_q;
    end
  end

  logic lead_edge, trail_edge, sample, cs_fall, cs_rise;
  assign lead_edge  = (sck_h_q == CPOL) && (sck_s2_q != CPOL);
  assign trail_edge = (sck_h_q != CPOL) && (sck_s2_q == CPOL);
  assign sample     = CPHA ? trail_edge : lead_edge;
  assign cs_fall    = cs_h_q && !cs_s2_q;
  assign cs_rise    = !cs_h_q && cs_s2_q;

  // The preset synchronisers would fake a CS_n fall if CS_n is already low at reset release,
  // so framing is armed only once real samples show CS_n high.
  logic [1:0]           flush_q, flush_d;
  logic                 armed_q, armed_d;
  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_BITS-2:0] sr_q, sr_d;
  logic                 extra_q, extra_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [WORD_BITS-1:0] sr_shift;
  logic                 commit;

  assign sr_shift = {sr_q, mosi_s2_q};

  always_comb begin
    flush_d     = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
    armed_d     = armed_q | ((flush_q == 2'd3) && cs_s2_q && cs_h_q);
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    extra_d     = extra_q;
    frame_err_d = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          extra_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_err_d = (cnt_q != '0);
          cnt_d       = '0;
        end else if (sample) begin
          sr_d = sr_shift[WORD_BITS-2:0];
          if (cnt_q == CW'(WORD_BITS - 1)) begin
            commit  = 1'b1;
            state_d = ST_WAIT_CS;
            cnt_d   = CW'(WORD_BITS);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT_CS: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_err_d = extra_q;
          extra_d     = 1'b0;
          cnt_d       = '0;
        end else if (sample) begin
          extra_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      flush_q     <= 2'd0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      extra_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      flush_q     <= flush_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      extra_q     <= extra_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_Frame_Err = frame_err_q;
  assign o_Overrun   = overrun_q;

  logic pop;
  assign pop = o_RX_DV && i_RX_Ready;

`ifdef SPI_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WORD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 empty, full, push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = commit && (!full || pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
    overrun_d = commit && full && !pop;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= sr_shift;
  end

  assign o_RX_DV   = !empty;
  assign o_RX_Word = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
`else
  logic [WORD_BITS-1:0] hold_word_q, hold_word_d;
  logic                 hold_dv_q, hold_dv_d;

  // A commit coinciding with a consume reuses the slot being freed.
  always_comb begin
    hold_word_d = hold_word_q;
    hold_dv_d   = hold_dv_q && !pop;
    overrun_d   = 1'b0;
    if (commit) begin
      if (!hold_dv_q || pop) begin
        hold_word_d = sr_shift;
        hold_dv_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hold_word_q <= '0;
      hold_dv_q   <= 1'b0;
    end else begin
      hold_word_q <= hold_word_d;
      hold_dv_q   <= hold_dv_d;
    end
  end

  assign o_RX_DV   = hold_dv_q;
  assign o_RX_Word = hold_word_q;
`endif

endmodule

// File: tb/tb_spi_rx_word.sv
// Bench for spi_rx_word: one instance per SPI mode shares a single frame stream; a frame-level
// model predicts delivered words, frame errors and overruns per group of frames.
`timescale 1ns/1ps
module tb_spi_rx_word;
  localparam int W = 14;
`ifdef SPI_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck_base = 1'b0;
  logic mosi = 1'b0;
  logic cs_n = 1'b1;
  logic ready = 1'b1;
  logic [3:0][W-1:0] rx_word;
  logic [3:0] dv, ferr, ovr;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    logic sck;
    assign sck = sck_base ^ (gi >= 2);
    spi_rx_word #(.SPI_MODE(gi), .WORD_BITS(W), .FIFO_DEPTH(4)) u_dut (
      .i_Clk      (clk),
      .i_Rst_L    (rst_n),
      .i_SPI_Clk  (sck),
      .i_SPI_MOSI (mosi),
      .i_SPI_CS_n (cs_n),
      .o_RX_Word  (rx_word[gi]),
      .o_RX_DV    (dv[gi]),
      .i_RX_Ready (ready),
      .o_Frame_Err(ferr[gi]),
      .o_Overrun  (ovr[gi])
    );
  end

  // Monitor: log every handshake and count flag pulses (one negedge per high cycle).
  typedef struct packed { logic [1:0] idx; logic [W-1:0] word; } got_t;
  got_t got_log [1024];
  int   got_n = 0;
  int   ferr_cnt [4] = '{default: 0};
  int   ovr_cnt  [4] = '{default: 0};

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (dv[i] && ready && got_n < 1024) begin
          got_log[got_n] = '{idx: 2'(i), word: rx_word[i]};
          got_n++;
        end
        if (ferr[i]) ferr_cnt[i]++;
        if (ovr[i])  ovr_cnt[i]++;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int exp_ferr, exp_ovr, held;
  int base_n;
  int base_ferr [4];
  int base_ovr  [4];

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Frame-level reference: a frame of exactly W bits is clean, any other non-empty length is a
  // frame error, and the first W bits of a long-enough frame form the delivered word.
  task automatic model_frame(input int nbits, input logic [15:0] bits);
    logic [15:0] sh;
    if (nbits != 0 && nbits != W) exp_ferr++;
    if (nbits >= W) begin
      sh = bits >> (nbits - W);
      if (ready) exp_q.push_back(sh[W-1:0]);
      else if (held < CAP) begin
        held++;
        exp_q.push_back(sh[W-1:0]);
      end else exp_ovr++;
    end
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    #40 sck_base = 1'b1;
    #40 sck_base = 1'b0;
    #20;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #40;
  endtask

  task automatic cs_high();
    #40 cs_n = 1'b1;
    #100;
  endtask

  task automatic send_frame(input int nbits, input logic [15:0] bits);
    $display("frame: %0d bits, data 0x%0h, ready %0b", nbits, bits, ready);
    cs_low();
    for (int k = nbits - 1; k >= 0; k--) send_bit(bits[k]);
    cs_high();
    model_frame(nbits, bits);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 ready = r;
    #2;
  endtask

  task automatic begin_group();
    base_n = got_n;
    for (int i = 0; i < 4; i++) begin
      base_ferr[i] = ferr_cnt[i];
      base_ovr[i]  = ovr_cnt[i];
    end
    exp_q.delete();
    exp_ferr = 0;
    exp_ovr  = 0;
    held     = 0;
  endtask

  task automatic end_group(input string name);
    logic [W-1:0] got[$];
    set_ready(1'b1);
    repeat (30) @(posedge clk);
    #3;
    for (int i = 0; i < 4; i++) begin
      got.delete();
      for (int k = base_n; k < got_n; k++)
        if (got_log[k].idx == 2'(i)) got.push_back(got_log[k].word);
      chk(got.size() == exp_q.size(), $sformatf("%s mode%0d word_count", name, i),
          got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got.size(); k++)
        chk(got[k] == exp_q[k], $sformatf("%s mode%0d word%0d", name, i, k),
            int'(got[k]), int'(exp_q[k]));
      chk(ferr_cnt[i] - base_ferr[i] == exp_ferr, $sformatf("%s mode%0d frame_err", name, i),
          ferr_cnt[i] - base_ferr[i], exp_ferr);
      chk(ovr_cnt[i] - base_ovr[i] == exp_ovr, $sformatf("%s mode%0d overrun", name, i),
          ovr_cnt[i] - base_ovr[i], exp_ovr);
      $display("group %s mode%0d: %0d words, %0d frame errors, %0d overruns", name, i,
               got.size(), ferr_cnt[i] - base_ferr[i], ovr_cnt[i] - base_ovr[i]);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    for (int i = 0; i < 4; i++) begin
      chk(rx_word[i] == '0, $sformatf("%s mode%0d word", name, i), int'(rx_word[i]), 0);
      chk({dv[i], ferr[i], ovr[i]} == 3'b000, $sformatf("%s mode%0d dv/ferr/ovr", name, i),
          int'({dv[i], ferr[i], ovr[i]}), 0);
    end
  endtask

  typedef struct {
    int          nbits;
    logic [15:0] bits;
    logic        rdy;
    bit          last;
    string       name;
  } vec_t;

  vec_t vecs [10];
  bit   in_group;
  int   nb;

  initial begin
    vecs[0] = '{14, 16'h2A5C, 1'b1, 1'b1, "basic"};
    vecs[1] = '{14, 16'h3FFF, 1'b1, 1'b0, "modes"};
    vecs[2] = '{14, 16'h0001, 1'b1, 1'b1, "modes"};
    vecs[3] = '{9,  16'h0155, 1'b1, 1'b0, "short"};
    vecs[4] = '{14, 16'h1234, 1'b1, 1'b1, "short"};
    vecs[5] = '{16, 16'h2AF3, 1'b1, 1'b1, "long"};
    vecs[6] = '{0,  16'h0000, 1'b1, 1'b1, "empty_cs"};
    vecs[7] = '{14, 16'h0011, 1'b0, 1'b0, "backpressure"};
    vecs[8] = '{14, 16'h0022, 1'b0, 1'b0, "backpressure"};
    vecs[9] = '{14, 16'h0033, 1'b0, 1'b1, "backpressure"};

    #20;
    chk_reset_outputs("in_reset");
    #7 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    for (int i = 0; i < 4; i++)
      chk(got_n == 0 && ferr_cnt[i] == 0 && ovr_cnt[i] == 0,
          $sformatf("after_reset mode%0d activity", i), got_n + ferr_cnt[i] + ovr_cnt[i], 0);

    in_group = 1'b0;
    for (int v = 0; v < 10; v++) begin
      if (!in_group) begin
        begin_group();
        in_group = 1'b1;
      end
      set_ready(vecs[v].rdy);
      send_frame(vecs[v].nbits, vecs[v].bits);
      if (vecs[v].last) begin
        end_group(vecs[v].name);
        in_group = 1'b0;
      end
    end

    // Reset in the middle of a frame; the remainder of that frame must be ignored.
    begin_group();
    cs_low();
    for (int k = 0; k < 7; k++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_frame_reset");
    #29 rst_n = 1'b1;
    for (int k = 0; k < 7; k++) send_bit(k[0]);
    cs_high();
    send_frame(14, 16'h1555);
    end_group("reset_mid_frame");

    for (int g = 0; g < 4; g++) begin
      begin_group();
      set_ready(1'($urandom_range(0, 1)));
      for (int f = 0; f < 5; f++) begin
        nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 16)) : W;
        send_frame(nb, 16'($urandom));
      end
      end_group($sformatf("random%0d", g));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
